// File: rtl/piso_shift.sv
// piso_shift: parallel-in serial-out shifter with valid/ready handshakes, MSB first.
// Optional macro PISO_SHIFT_PARITY_EN appends an even-parity beat after the data bits.
module piso_shift #(
  parameter int unsigned          depth_p     = 5,
  parameter logic [depth_p-1:0]   reset_val_p = '0
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic [depth_p-1:0] data_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic               data_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               last_o
);

`ifdef PISO_SHIFT_PARITY_EN
  localparam int unsigned last_idx = depth_p;
`else
  localparam int unsigned last_idx = depth_p - 1;
`endif
  localparam int unsigned cnt_w = (last_idx < 2) ? 1 : $clog2(last_idx + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [depth_p-1:0] shreg_q, shreg_d;
  logic [cnt_w-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               shift_fill;

`ifdef PISO_SHIFT_PARITY_EN
  logic parity_q, parity_d;

  // Parity enters the LSB on the first shift so it reaches the MSB on the extra beat.
  assign shift_fill = (cnt_q == '0) ? parity_q : 1'b0;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) parity_q <= 1'b0;
    else           parity_q <= parity_d;
  end
`else
  assign shift_fill = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      shreg_q <= reset_val_p;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    last_d  = last_q;
`ifdef PISO_SHIFT_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          state_d = SHIFT;
          shreg_d = data_i;
          cnt_d   = '0;
          valid_d = 1'b1;
          last_d  = 1'b0;
`ifdef PISO_SHIFT_PARITY_EN
          parity_d = ^data_i;
`endif
        end
      end
      SHIFT: begin
        if (ready_i) begin
          if (!last_q) begin
            shreg_d = {shreg_q[depth_p-2:0], shift_fill};
            cnt_d   = cnt_q + cnt_w'(1);
            last_d  = (cnt_q == cnt_w'(last_idx - 1));
          end else if (valid_i) begin
            // Reload on the final beat keeps the serial stream gap-free.
            shreg_d = data_i;
            cnt_d   = '0;
            last_d  = 1'b0;
`ifdef PISO_SHIFT_PARITY_EN
            parity_d = ^data_i;
`endif
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready_o = (state_q == IDLE) | ((state_q == SHIFT) & last_q & ready_i);
  assign data_o  = shreg_q[depth_p-1];
  assign valid_o = valid_q;
  assign last_o  = last_q;

endmodule

// File: tb/tb_piso_shift.sv
// Self-checking bench for piso_shift: vector table plus handshake, back-to-back and reset sequences.
`timescale 1ns/1ps
module tb_piso_shift;
  localparam int unsigned W = 5;
`ifdef PISO_SHIFT_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk;
  logic         reset_ni;
  logic [W-1:0] data_i;
  logic         valid_i;
  logic         ready_o;
  logic         data_o;
  logic         valid_o;
  logic         ready_i;
  logic         last_o;
  logic [W-1:0] rx;

  piso_shift #(.depth_p(W), .reset_val_p('0)) dut (
    .clk_i   (clk),
    .reset_ni(reset_ni),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .last_o  (last_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial-in receiver rebuilding the word from accepted beats.
  always @(posedge clk or negedge reset_ni) begin
    if (!reset_ni)              rx <= '0;
    else if (valid_o && ready_i) rx <= {rx[W-2:0], data_o};
  end

  typedef struct packed {
    logic bit_v;
    logic last_v;
  } beat_t;

  typedef struct {
    logic [W-1:0] word;
    int           stall_at;
    int           stall_len;
    bit           rnd;
  } vec_t;

  beat_t q[$];
  vec_t  vecs[7];
  int    tests = 0;
  int    fails = 0;
  bit    prev_stall = 1'b0;
  logic  pd, pl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic void push_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) begin
`ifdef PISO_SHIFT_PARITY_EN
      q.push_back('{bit_v: w[i], last_v: 1'b0});
`else
      q.push_back('{bit_v: w[i], last_v: (i == 0)});
`endif
    end
`ifdef PISO_SHIFT_PARITY_EN
    q.push_back('{bit_v: ^w, last_v: 1'b1});
`endif
  endfunction

  function automatic logic [W-1:0] exp_rx(input logic [W-1:0] w);
`ifdef PISO_SHIFT_PARITY_EN
    return {w[W-2:0], ^w};
`else
    return w;
`endif
  endfunction

  // Negedge monitor: scoreboard pop/push and stall stability.
  task automatic tick();
    beat_t e;
    @(negedge clk);
    if (!reset_ni) begin
      q.delete();
      prev_stall = 1'b0;
      return;
    end
    if (prev_stall) begin
      check("stall_valid", valid_o, 1);
      check("stall_data", data_o, pd);
      check("stall_last", last_o, pl);
    end
    prev_stall = valid_o && !ready_i;
    pd = data_o;
    pl = last_o;
    if (valid_o && ready_i) begin
      if (q.size() == 0) fail_now("unexpected_beat");
      else begin
        e = q.pop_front();
        check("beat_data", data_o, e.bit_v);
        check("beat_last", last_o, e.last_v);
      end
    end
    if (valid_i && ready_o) push_word(data_i);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [W-1:0] w);
    bit acc;
    int n;
    valid_i = 1'b1;
    data_i  = w;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      tick();
      acc = ready_o;
      step();
      n++;
    end
    if (!acc) fail_now("accept_timeout");
  endtask

  task automatic run_word(input logic [W-1:0] w, input int stall_at, input int stall_len, input bit rnd);
    int hs, vc, st, stl, n;
    bit done;
    ready_i = 1'b1;
    accept(w);
    valid_i = 1'b0;
    hs = 0; vc = 0; st = 0; stl = 0; n = 0; done = 1'b0;
    while (!done && n < 200) begin
      if (rnd) ready_i = 1'($urandom_range(0, 1));
      else if (hs == stall_at && st < stall_len) begin
        ready_i = 1'b0;
        st++;
      end else ready_i = 1'b1;
      tick();
      if (valid_o) vc++;
      if (valid_o && !ready_i) stl++;
      if (valid_o && ready_i) begin
        hs++;
        done = last_o;
      end
      step();
      n++;
    end
    ready_i = 1'b1;
    if (!done) fail_now("word_timeout");
    check("handshakes", hs, NB);
    check("valid_cycles", vc, NB + stl);
    if (!rnd) check("stall_cycles", stl, stall_len);
    check("loopback_rx", rx, exp_rx(w));
  endtask

  initial begin
    int k, n;
    vecs[0] = '{word: 5'b10110, stall_at: -1, stall_len: 0, rnd: 1'b0};
    vecs[1] = '{word: 5'b10110, stall_at: 2,  stall_len: 3, rnd: 1'b0};
    vecs[2] = '{word: 5'b11111, stall_at: 0,  stall_len: 2, rnd: 1'b0};
    vecs[3] = '{word: 5'b00001, stall_at: NB - 1, stall_len: 1, rnd: 1'b0};
    vecs[4] = '{word: 5'b01101, stall_at: -1, stall_len: 0, rnd: 1'b1};
    vecs[5] = '{word: 5'b10011, stall_at: -1, stall_len: 0, rnd: 1'b1};
    vecs[6] = '{word: W'($urandom), stall_at: -1, stall_len: 0, rnd: 1'b1};

    data_i = '0; valid_i = 1'b0; ready_i = 1'b1;
    reset_ni = 1'b1;
    #2 reset_ni = 1'b0;
    #1;
    check("rst_valid", valid_o, 0);
    check("rst_ready", ready_o, 1);
    check("rst_last", last_o, 0);
    check("rst_data", data_o, 0);
    step();
    step();
    reset_ni = 1'b1;
    tick();
    step();

    for (int i = 0; i < 7; i++)
      run_word(vecs[i].word, vecs[i].stall_at, vecs[i].stall_len, vecs[i].rnd);

    // Two words back to back with valid_i held: contiguous beats, ready_o only on last beats.
    ready_i = 1'b1;
    accept(5'b11001);
    data_i = 5'b00111;
    for (int c = 0; c < 2 * NB; c++) begin
      tick();
      check("b2b_valid", valid_o, 1);
      check("b2b_ready", ready_o, ((c % NB) == NB - 1));
      step();
      if (c == NB - 1) valid_i = 1'b0;
    end
    tick();
    check("b2b_idle", valid_o, 0);
    step();

    // Reset asserted mid-word while beat 3 is on the line.
    accept(5'b10110);
    valid_i = 1'b0;
    k = 0; n = 0;
    while (k < 2 && n < 20) begin
      tick();
      if (valid_o && ready_i) k++;
      step();
      n++;
    end
    if (k < 2) fail_now("midword_timeout");
    check("beat3_before_reset", data_o, 1);
    #2 reset_ni = 1'b0;
    #1;
    check("mid_rst_valid", valid_o, 0);
    check("mid_rst_ready", ready_o, 1);
    check("mid_rst_last", last_o, 0);
    check("mid_rst_data", data_o, 0);
    tick();
    step();
    tick();
    step();
    reset_ni = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("post_rst_idle", valid_o, 0);
      step();
    end
    run_word(5'b01010, -1, 0, 1'b0);

    for (int c = 0; c < 3; c++) begin
      tick();
      step();
    end
    check("queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
